// File: rtl/pixel_clip_fifo_if.sv
// Pixel stream bundle: circle-drawer side (in_*) and framebuffer side (out_*).
// master drives the pixel source and framebuffer ready; slave is the clip FIFO.
interface pixel_clip_fifo_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
);
  logic [X_W-1:0]      in_x;
  logic [Y_W-1:0]      in_y;
  logic [COLOUR_W-1:0] in_colour;
  logic                in_plot;
  logic                in_ready;
  logic [X_W-1:0]      out_x;
  logic [Y_W-1:0]      out_y;
  logic [COLOUR_W-1:0] out_colour;
  logic                out_plot;
  logic                out_ready;

  modport master (
    output in_x, in_y, in_colour, in_plot, out_ready,
    input  in_ready, out_x, out_y, out_colour, out_plot
  );

  modport slave (
    input  in_x, in_y, in_colour, in_plot, out_ready,
    output in_ready, out_x, out_y, out_colour, out_plot
  );
endinterface

// File: rtl/pixel_clip_fifo.sv
// Clips off-screen pixels and queues on-screen ones in a registered FWFT FIFO; latency 1.
// Upstream stalls on in_ready (=!full, clipped pixels included); done waits for a full drain.
module pixel_clip_fifo #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int DEPTH    = 8,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  localparam int CW      = $clog2(DEPTH + 1),
  localparam int PW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  pixel_clip_fifo_if.slave pix,
  input  logic          in_done,
  output logic          done,
  output logic [CW-1:0] count,
  output logic [15:0]   drop_count,
  input  logic          clear_drops
);

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } pix_t;

  pix_t          mem [DEPTH];
  pix_t          in_pix;
  pix_t          head_q;
  pix_t          head_next;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_ptr_next;
  logic [CW-1:0] count_next;
  logic          full;
  logic          empty;
  logic          push_req;
  logic          on_screen;
  logic          store;
  logic          clip;
  logic          pop;

  assign in_pix    = '{x: pix.in_x, y: pix.in_y, colour: pix.in_colour};
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign push_req  = pix.in_plot & ~full;
  assign on_screen = ({1'b0, pix.in_x} < (X_W + 1)'(SCREEN_W)) &&
                     ({1'b0, pix.in_y} < (Y_W + 1)'(SCREEN_H));
  assign store     = push_req & on_screen;
  assign clip      = push_req & ~on_screen;
  assign pop       = ~empty & pix.out_ready;

  assign count_next  = count + CW'(store) - CW'(pop);
  assign rd_ptr_next = rd_ptr + PW'(pop);

  // The head register is reloaded every cycle from the entry that will be at the head
  // after this edge; when the FIFO is (or becomes) otherwise empty that entry is the
  // incoming pixel, which is not yet in mem.
  always_comb begin
    head_next = head_q;
    if (count_next != '0) begin
      if (store && (count == CW'(pop))) begin
        head_next = in_pix;
      end else begin
        head_next = mem[rd_ptr_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr] <= in_pix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head_q <= '0;
      done   <= 1'b0;
    end else begin
      if (store) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
      head_q <= head_next;
      done   <= in_done & (count_next == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (clear_drops) begin
      drop_count <= '0;
    end else if (clip && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end

  assign pix.in_ready   = ~full;
  assign pix.out_plot   = ~empty;
  assign pix.out_x      = head_q.x;
  assign pix.out_y      = head_q.y;
  assign pix.out_colour = head_q.colour;

endmodule
